// File: rtl/seq_divider4.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Optional two's-complement mode with an extra fix-up cycle: define SEQ_DIVIDER4_SIGNED_EN.
module seq_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is accepted only on an edge where the FSM is IDLE; operands are
  // captured on that edge. done is a single-cycle pulse and results hold until the next completion.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
`ifdef SEQ_DIVIDER4_SIGNED_EN
    , S_FIX  = 2'd3
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_p_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

`ifdef SEQ_DIVIDER4_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = dividend[WIDTH-1];
  assign w_b_neg = divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? -dividend : dividend;
  assign w_b_mag = w_b_neg ? -divisor : divisor;
`else
  assign w_a_mag = dividend;
  assign w_b_mag = divisor;
`endif

  // The restored remainder is always below the divisor, so P's top bit is only needed
  // transiently in the trial subtraction and is not stored.
  assign w_shift    = {r_p, r_dvd[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_fits     = ~w_trial[WIDTH];
  assign w_p_next   = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  // Quotient bits shift into the dividend register as its bits are consumed.
  assign w_q_next   = {r_dvd[WIDTH-2:0], w_fits};
  assign w_last     = (r_cnt == CW'(1));
  assign w_dvs_zero = (divisor == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = w_dvs_zero ? S_DONE : S_RUN;
`ifdef SEQ_DIVIDER4_SIGNED_EN
      S_RUN:  if (w_last) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_DONE;
`else
      S_RUN:  if (w_last) w_state_next = S_DONE;
`endif
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
`ifdef SEQ_DIVIDER4_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_dvd <= w_a_mag;
          r_dvs <= w_b_mag;
          r_p   <= '0;
          r_cnt <= CW'(WIDTH);
`ifdef SEQ_DIVIDER4_SIGNED_EN
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
`endif
          if (w_dvs_zero) begin
            r_quotient  <= '1;
            r_remainder <= dividend;
            r_dbz       <= 1'b1;
          end else begin
            r_dbz <= 1'b0;
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_dvd <= w_q_next;
          r_cnt <= r_cnt - CW'(1);
`ifndef SEQ_DIVIDER4_SIGNED_EN
          if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_p_next;
          end
`endif
        end
`ifdef SEQ_DIVIDER4_SIGNED_EN
        S_FIX: begin
          r_quotient  <= r_neg_q ? -r_dvd : r_dvd;
          r_remainder <= r_neg_r ? -r_p : r_p;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider4.sv
// Bench for seq_divider4: directed cases plus random operands, scoreboarded against an arithmetic model.
module tb_seq_divider4;

  localparam int W  = 4;
  localparam int EW = 1 + 2*W + 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [W-1:0] held_q = '0;
  logic [W-1:0] held_r = '0;

  seq_divider4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain arithmetic; returns {dbz, q, r, expected done cycle}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input int issue_cyc);
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           sa;
    int           sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1; lat = 0;
    end else begin
      z = 1'b0;
`ifdef SEQ_DIVIDER4_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
      lat = W + 1;
`else
      sa = int'(a);
      sb = int'(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
      lat = W;
`endif
    end
    return {z, q, r, 16'(issue_cyc + 1 + lat)};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    exp_q.push_back(model(a, b, cyc));
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", seen, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_done();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      held_q = '0;
      held_r = '0;
    end else begin
      if (busy) begin
        busy_cnt++;
        check("hold_quotient", quotient, held_q);
        check("hold_remainder", remainder, held_r);
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1, required no pending operation (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("div_by_zero", div_by_zero, e[EW-1]);
          check("quotient", quotient, e[EW-2 -: W]);
          check("remainder", remainder, e[16 +: W]);
          check("done_cycle", cyc, e[15:0]);
          check("busy_cycles", busy_cnt, e[EW-1] ? 0 : W);
        end
        busy_cnt = 0;
        held_q = quotient;
        held_r = remainder;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;

    run_op(4'd13, 4'd3);
    run_op(4'd7, 4'd0);
    run_op(4'd13, 4'd1);
    run_op(4'd15, 4'd1);
    run_op(4'd2, 4'd5);
    run_op(4'd0, 4'd9);
    run_op(4'd15, 4'd15);

    // start re-asserted with new operands while running must be ignored
    issue(4'd13, 4'd3);
    start = 1'b1;
    dividend = 4'd9;
    divisor = 4'd2;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done();
    run_op(4'd9, 4'd2);

    // asynchronous reset in the second RUN cycle aborts the operation
    issue(4'd13, 4'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", div_by_zero, 0);
    check("abort_state", dbg_state, 0);
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    check("no_done_after_abort", done_cnt, d0);
    run_op(4'd10, 4'd3);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
      run_op(a, b);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
